// File: rtl/eth_mii_tx_framer_if.sv
// Byte-stream handshake plus MII transmit pins of the Ethernet TX framer.
// The master is the TX DMA/FIFO side and the slave is the framer.
interface eth_mii_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_abort;
    logic       MTxEn;
    logic [3:0] MTxD;
    logic       MTxErr;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data, tx_valid, tx_last, tx_abort,
        input  tx_ready, MTxEn, MTxD, MTxErr, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid, tx_last, tx_abort,
        output tx_ready, MTxEn, MTxD, MTxErr, tx_busy, tx_done
    );
endinterface

// File: rtl/eth_mii_tx_framer.sv
// MII transmit framer: preamble/SFD, payload nibbles, optional zero padding,
// CRC-32 FCS and inter-frame gap, with abort/underrun signalled on MTxErr.
module eth_mii_tx_framer #(
    parameter int PREAMBLE_NIBBLES  = 15,
    parameter int IFG_NIBBLES       = 24,
    parameter int MIN_PAYLOAD_BYTES = 60,
    parameter bit PAD_EN            = 1'b1
) (
    input logic               MTxClk,
    input logic               prstn_i,
    eth_mii_tx_framer_if.slave tx
);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, PAD_LO, PAD_HI, FCS, IFG
    } state_t;

    state_t      state_r;
    logic        mtx_en_r;
    logic [3:0]  mtxd_r;
    logic        mtx_err_r;
    logic        tx_ready_r;
    logic        tx_busy_r;
    logic        tx_done_r;
    logic [31:0] crc_r;
    logic [31:0] fcs_sh_r;
    logic [7:0]  byte_r;
    logic        last_r;
    logic [10:0] byte_cnt_r;
    logic [15:0] cnt_r;

    logic        hs_s;
    logic        abort_s;
    logic [10:0] byte_cnt_inc_s;
    logic [31:0] crc_byte_s;
    logic [31:0] crc_pad_s;
    logic [31:0] fcs_byte_s;
    logic [31:0] fcs_pad_s;

    // Reflected CRC-32 (poly 0xEDB88320) advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign hs_s           = tx.tx_valid & tx_ready_r;
    assign abort_s        = tx.tx_abort & (state_r != IDLE) & (state_r != IFG);
    assign byte_cnt_inc_s = (byte_cnt_r == 11'd2047) ? byte_cnt_r : byte_cnt_r + 11'd1;
    assign crc_byte_s     = crc32_byte(crc_r, byte_r);
    assign crc_pad_s      = crc32_byte(crc_r, 8'h00);
    assign fcs_byte_s     = ~crc_byte_s;
    assign fcs_pad_s      = ~crc_pad_s;

    assign tx.tx_ready = tx_ready_r;
    assign tx.MTxEn    = mtx_en_r;
    assign tx.MTxD     = mtxd_r;
    assign tx.MTxErr   = mtx_err_r;
    assign tx.tx_busy  = tx_busy_r;
    assign tx.tx_done  = tx_done_r;

    // Framing state machine; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge MTxClk or negedge prstn_i) begin
        if (!prstn_i) begin
            state_r    <= IDLE;
            mtx_en_r   <= 1'b0;
            mtxd_r     <= 4'h0;
            mtx_err_r  <= 1'b0;
            tx_ready_r <= 1'b0;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
            crc_r      <= 32'hFFFF_FFFF;
            fcs_sh_r   <= 32'h0;
            byte_r     <= 8'h00;
            last_r     <= 1'b0;
            byte_cnt_r <= 11'd0;
            cnt_r      <= 16'd0;
        end else begin
            tx_done_r <= 1'b0;
            if (abort_s) begin
                state_r    <= IFG;
                mtx_err_r  <= 1'b1;
                mtx_en_r   <= 1'b1;
                mtxd_r     <= 4'h0;
                tx_ready_r <= 1'b0;
                crc_r      <= 32'hFFFF_FFFF;
                cnt_r      <= 16'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        tx_ready_r <= 1'b1;
                        if (hs_s) begin
                            byte_r     <= tx.tx_data;
                            last_r     <= tx.tx_last;
                            byte_cnt_r <= 11'd0;
                            tx_busy_r  <= 1'b1;
                            tx_ready_r <= 1'b0;
                            mtx_en_r   <= 1'b1;
                            mtxd_r     <= 4'h5;
                            cnt_r      <= 16'd0;
                            state_r    <= PREAMBLE;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    PREAMBLE: begin
                        if (cnt_r == 16'(PREAMBLE_NIBBLES - 1)) begin
                            mtxd_r  <= 4'hD;
                            state_r <= SFD;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    SFD: begin
                        mtxd_r  <= byte_r[3:0];
                        state_r <= DATA_LO;
                    end
                    DATA_LO: begin
                        mtxd_r     <= byte_r[7:4];
                        tx_ready_r <= ~last_r;
                        state_r    <= DATA_HI;
                    end
                    DATA_HI: begin
                        crc_r      <= crc_byte_s;
                        byte_cnt_r <= byte_cnt_inc_s;
                        tx_ready_r <= 1'b0;
                        if (last_r) begin
                            if (PAD_EN && (byte_cnt_inc_s < 11'(MIN_PAYLOAD_BYTES))) begin
                                mtxd_r  <= 4'h0;
                                state_r <= PAD_LO;
                            end else begin
                                mtxd_r   <= fcs_byte_s[3:0];
                                fcs_sh_r <= fcs_byte_s >> 4;
                                cnt_r    <= 16'd0;
                                state_r  <= FCS;
                            end
                        end else if (hs_s) begin
                            byte_r  <= tx.tx_data;
                            last_r  <= tx.tx_last;
                            mtxd_r  <= tx.tx_data[3:0];
                            state_r <= DATA_LO;
                        end else begin
                            // Source starved the byte stream mid-frame: treated as an abort.
                            mtx_err_r <= 1'b1;
                            mtxd_r    <= 4'h0;
                            crc_r     <= 32'hFFFF_FFFF;
                            cnt_r     <= 16'd0;
                            state_r   <= IFG;
                        end
                    end
                    PAD_LO: begin
                        mtxd_r  <= 4'h0;
                        state_r <= PAD_HI;
                    end
                    PAD_HI: begin
                        crc_r      <= crc_pad_s;
                        byte_cnt_r <= byte_cnt_inc_s;
                        if (byte_cnt_inc_s >= 11'(MIN_PAYLOAD_BYTES)) begin
                            mtxd_r   <= fcs_pad_s[3:0];
                            fcs_sh_r <= fcs_pad_s >> 4;
                            cnt_r    <= 16'd0;
                            state_r  <= FCS;
                        end else begin
                            mtxd_r  <= 4'h0;
                            state_r <= PAD_LO;
                        end
                    end
                    FCS: begin
                        if (cnt_r == 16'd7) begin
                            mtx_en_r  <= 1'b0;
                            mtxd_r    <= 4'h0;
                            tx_done_r <= 1'b1;
                            crc_r     <= 32'hFFFF_FFFF;
                            cnt_r     <= 16'd0;
                            state_r   <= IFG;
                        end else begin
                            mtxd_r   <= fcs_sh_r[3:0];
                            fcs_sh_r <= fcs_sh_r >> 4;
                            cnt_r    <= cnt_r + 16'd1;
                        end
                    end
                    IFG: begin
                        // The error cycle of an abort is not part of the idle gap.
                        if (mtx_err_r) begin
                            mtx_err_r <= 1'b0;
                            mtx_en_r  <= 1'b0;
                        end else if (cnt_r == 16'(IFG_NIBBLES - 1)) begin
                            tx_ready_r <= 1'b1;
                            tx_busy_r  <= 1'b0;
                            cnt_r      <= 16'd0;
                            state_r    <= IDLE;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    default: begin
                        mtx_en_r   <= 1'b0;
                        mtxd_r     <= 4'h0;
                        mtx_err_r  <= 1'b0;
                        tx_ready_r <= 1'b0;
                        tx_busy_r  <= 1'b0;
                        crc_r      <= 32'hFFFF_FFFF;
                        state_r    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_mii_tx_framer.sv
// Directed bench for eth_mii_tx_framer: one instance without padding, one with.
module tb_eth_mii_tx_framer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    eth_mii_tx_framer_if if0 ();
    eth_mii_tx_framer_if if1 ();

    eth_mii_tx_framer #(.PAD_EN(1'b0)) dut0 (.MTxClk(clk), .prstn_i(rst_n), .tx(if0));
    eth_mii_tx_framer #(.PAD_EN(1'b1)) dut1 (.MTxClk(clk), .prstn_i(rst_n), .tx(if1));

    logic       sel;
    logic [7:0] b_data;
    logic       b_valid, b_last, b_abort;

    assign if0.tx_data  = b_data;
    assign if0.tx_valid = b_valid & ~sel;
    assign if0.tx_last  = b_last;
    assign if0.tx_abort = b_abort & ~sel;
    assign if1.tx_data  = b_data;
    assign if1.tx_valid = b_valid & sel;
    assign if1.tx_last  = b_last;
    assign if1.tx_abort = b_abort & sel;

    logic       o_en, o_err, o_rdy, o_busy, o_done;
    logic [3:0] o_d;
    assign o_en   = sel ? if1.MTxEn    : if0.MTxEn;
    assign o_d    = sel ? if1.MTxD     : if0.MTxD;
    assign o_err  = sel ? if1.MTxErr   : if0.MTxErr;
    assign o_rdy  = sel ? if1.tx_ready : if0.tx_ready;
    assign o_busy = sel ? if1.tx_busy  : if0.tx_busy;
    assign o_done = sel ? if1.tx_done  : if0.tx_done;

    typedef struct {
        logic        sel;
        int          len;
        logic [7:0]  base;
        logic [7:0]  step;
        int          exp_en;
        bit          chk_const;
        logic [31:0] fcs_const;
    } vec_t;

    vec_t tbl[6];
    int checks = 0;
    int errors = 0;

    logic [3:0] got[$];
    int en_cnt, done_cnt, err_cnt, err_bad, busy_bad, done_cyc, err_cyc, rdy_cyc, timeout;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
        return c;
    endfunction

    // Presents len bytes, each held until a ready cycle lets it transfer.
    task automatic drive(input int len, input logic [7:0] base, input logic [7:0] step, input bit give_last);
        for (int i = 0; i < len; i++) begin
            int guard;
            b_data  = 8'(int'(base) + i * int'(step));
            b_valid = 1'b1;
            b_last  = give_last && (i == len - 1);
            guard   = 0;
            while (!o_rdy && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                chk("drive_ready_timeout", 0, 1);
                b_valid = 1'b0;
                b_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    // Records MII activity until tx_ready returns after a done or error cycle.
    task automatic mon(input int limit);
        en_cnt = 0; done_cnt = 0; err_cnt = 0; err_bad = 0; busy_bad = 0;
        done_cyc = 0; err_cyc = 0; rdy_cyc = 0; timeout = 0;
        got.delete();
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (o_err) begin
                err_cnt++;
                err_cyc = c;
                if (!o_en || o_d != 4'h0) err_bad++;
            end else if (o_en) begin
                en_cnt++;
                got.push_back(o_d);
            end
            if ((o_en || o_done) && !o_busy) busy_bad++;
            if (o_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (o_rdy && (done_cnt + err_cnt) > 0) begin
                if (o_busy) busy_bad++;
                rdy_cyc = c;
                return;
            end
        end
        timeout = 1;
    endtask

    task automatic run_vec(input int k);
        logic [7:0]  bytes[$];
        logic [3:0]  expq[$];
        logic [31:0] crc, f;
        int          mis;
        sel = tbl[k].sel;
        fork
            drive(tbl[k].len, tbl[k].base, tbl[k].step, 1'b1);
            mon(3000);
        join
        for (int i = 0; i < tbl[k].len; i++) bytes.push_back(8'(int'(tbl[k].base) + i * int'(tbl[k].step)));
        while (tbl[k].sel && bytes.size() < 60) bytes.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 15; i++) expq.push_back(4'h5);
        expq.push_back(4'hD);
        foreach (bytes[i]) begin
            expq.push_back(bytes[i][3:0]);
            expq.push_back(bytes[i][7:4]);
            for (int b = 0; b < 8; b++) crc = crc_bit(crc, bytes[i][b]);
        end
        crc = ~crc;
        for (int j = 0; j < 8; j++) expq.push_back(crc[4*j +: 4]);
        mis = -1;
        if (got.size() != expq.size()) begin
            mis = -2;
        end else begin
            foreach (got[i]) if (mis < 0 && got[i] != expq[i]) mis = i;
        end
        chk($sformatf("v%0d_en_cycles", k), en_cnt, tbl[k].exp_en);
        chk($sformatf("v%0d_stream_first_bad_nibble", k), mis, -1);
        chk($sformatf("v%0d_done_pulses", k), done_cnt, 1);
        chk($sformatf("v%0d_err_cycles", k), err_cnt, 0);
        chk($sformatf("v%0d_ifg_gap", k), rdy_cyc - done_cyc, 24);
        chk($sformatf("v%0d_busy_violations", k), busy_bad, 0);
        chk($sformatf("v%0d_timeout", k), timeout, 0);
        if (tbl[k].chk_const) begin
            f = 32'h0;
            if (got.size() >= 8) for (int j = 0; j < 8; j++) f[4*j +: 4] = got[got.size() - 8 + j];
            chk($sformatf("v%0d_fcs", k), int'(f), int'(tbl[k].fcs_const));
        end
    endtask

    initial begin
        int n, g;
        tbl[0] = '{1'b0,  9, 8'h31, 8'h01,  42, 1'b1, 32'hCBF43926};
        tbl[1] = '{1'b1,  1, 8'hAB, 8'h00, 144, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 64, 8'h00, 8'h01, 152, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 60, 8'hF0, 8'h03, 144, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 59, 8'h07, 8'h05, 144, 1'b0, 32'h0};
        tbl[5] = '{1'b0,  3, 8'hA5, 8'h01,  30, 1'b0, 32'h0};

        sel = 1'b0; b_data = 8'h00; b_valid = 1'b0; b_last = 1'b0; b_abort = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset_outputs_pad0", int'({if0.MTxEn, if0.MTxD, if0.MTxErr, if0.tx_ready, if0.tx_busy, if0.tx_done}), 0);
        chk("reset_outputs_pad1", int'({if1.MTxEn, if1.MTxD, if1.MTxErr, if1.tx_ready, if1.tx_busy, if1.tx_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(o_rdy), 1);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Underrun: five bytes without tx_last, then the source goes quiet.
        sel = 1'b1;
        fork
            drive(5, 8'h10, 8'h11, 1'b0);
            mon(3000);
        join
        chk("underrun_data_nibbles", en_cnt, 26);
        chk("underrun_err_cycles", err_cnt, 1);
        chk("underrun_err_shape", err_bad, 0);
        chk("underrun_done_pulses", done_cnt, 0);
        chk("underrun_gap", rdy_cyc - err_cyc, 25);
        run_vec(1);

        // Abort raised during the fourth preamble nibble.
        sel = 1'b1;
        fork
            drive(1, 8'h5A, 8'h00, 1'b1);
            mon(3000);
            begin
                n = 0; g = 0;
                while (n < 4 && g < 100) begin
                    @(negedge clk);
                    g++;
                    if (o_en) n++;
                end
                b_abort = 1'b1;
                @(posedge clk);
                #1 b_abort = 1'b0;
            end
        join
        chk("abort_preamble_nibbles", int'(got.size()), 4);
        chk("abort_err_cycles", err_cnt, 1);
        chk("abort_err_shape", err_bad, 0);
        chk("abort_done_pulses", done_cnt, 0);
        chk("abort_gap", rdy_cyc - err_cyc, 25);
        run_vec(0);

        // Reset pulled in the middle of the FCS nibbles.
        sel = 1'b0;
        fork
            drive(9, 8'h31, 8'h01, 1'b1);
            begin
                n = 0; g = 0;
                while (n < 37 && g < 300) begin
                    @(negedge clk);
                    g++;
                    if (o_en) n++;
                end
                #1 rst_n = 1'b0;
                #1;
                chk("reset_mid_fcs_async", int'({o_en, o_d, o_err}), 0);
            end
        join
        @(negedge clk);
        chk("reset_mid_fcs_held", int'({o_en, o_err, o_rdy, o_busy, o_done}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_reset", int'(o_rdy), 1);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
